// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSED = 2'd1,
      LOAD   = 2'd2
   } state_t;

   typedef logic [7:0] bcd2_t;

   localparam bcd2_t SEC_MAX  = 8'h59;
   localparam bcd2_t MIN_MAX  = 8'h59;
   localparam bcd2_t HR24_MAX = 8'h23;
   localparam bcd2_t HR12_MAX = 8'h12;

   function automatic bcd2_t bcd2_inc(input bcd2_t v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Packed BCD compares numerically once both digits are known to be 0..9.
   function automatic logic bcd2_in_range(input bcd2_t v, input bcd2_t lo, input bcd2_t hi);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter: load beats inc, WRAP_VAL rolls to RESTART_VAL with carry.
// Count updates one cycle after inc/load; carry is combinational and only valid with inc.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter bcd2_t WRAP_VAL    = SEC_MAX,
   parameter bcd2_t RESTART_VAL = 8'h00,
   parameter bcd2_t RESET_VAL   = 8'h00
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_n_i,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] count,
   output logic       carry
);

   assign carry = inc && (count == WRAP_VAL);

   always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count <= RESET_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (inc) begin
         count <= carry ? RESTART_VAL : bcd2_inc(count);
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter (24h or 12h+pm by FORMAT_24H); optional alarm when ALARM_EN is defined.
// Ticks show on outputs next cycle, loads resolve one cycle after load_i; no backpressure, ticks in PAUSED/LOAD are dropped.
module bcd_time_counter
   import clock_pkg::*;
#(
   parameter bit FORMAT_24H = 1'b1
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_n_i,
   input  logic       second_pulse_i,
   input  logic       pause_i,
   input  logic       load_i,
   input  logic [7:0] load_hh_i,
   input  logic [7:0] load_mm_i,
   input  logic [7:0] load_ss_i,
`ifdef ALARM_EN
   input  logic       alarm_set_i,
   input  logic [7:0] alarm_hh_i,
   input  logic [7:0] alarm_mm_i,
   input  logic       alarm_pm_i,
   output logic       alarm_o,
`endif
   output logic       load_ack_o,
   output logic       load_err_o,
   output logic [7:0] hours_o,
   output logic [7:0] minutes_o,
   output logic [7:0] seconds_o,
   output logic       pm_o,
   output logic       minute_tick_o,
   output logic       day_wrap_o
);

   localparam bcd2_t HR_MAX     = FORMAT_24H ? HR24_MAX : HR12_MAX;
   localparam bcd2_t HR_MIN     = FORMAT_24H ? 8'h00 : 8'h01;
   localparam bcd2_t HR_RESTART = FORMAT_24H ? 8'h00 : 8'h01;
   localparam bcd2_t HR_RST     = FORMAT_24H ? 8'h00 : 8'h12;

   state_t state;
   bcd2_t  ld_hh, ld_mm, ld_ss;
   logic   pm_q;
   logic   advance, load_ok, load_wr;
   logic   sec_carry, min_carry, hr_carry, pm_flip;

   // A tick arriving together with load_i is dropped, as is any tick outside RUN.
   assign advance = (state == RUN) && second_pulse_i && !load_i;
   assign load_ok = bcd2_in_range(ld_ss, 8'h00, SEC_MAX) &&
                    bcd2_in_range(ld_mm, 8'h00, MIN_MAX) &&
                    bcd2_in_range(ld_hh, HR_MIN, HR_MAX);
   assign load_wr = (state == LOAD) && load_ok;
   assign pm_flip = !FORMAT_24H && min_carry && (hours_o == 8'h11);
   assign pm_o    = pm_q;

   bcd_mod_counter #(.WRAP_VAL(SEC_MAX), .RESTART_VAL(8'h00), .RESET_VAL(8'h00)) u_sec (
      .clk_100MHz_i (clk_100MHz_i),
      .reset_n_i    (reset_n_i),
      .inc          (advance),
      .load         (load_wr),
      .load_val     (ld_ss),
      .count        (seconds_o),
      .carry        (sec_carry)
   );

   bcd_mod_counter #(.WRAP_VAL(MIN_MAX), .RESTART_VAL(8'h00), .RESET_VAL(8'h00)) u_min (
      .clk_100MHz_i (clk_100MHz_i),
      .reset_n_i    (reset_n_i),
      .inc          (sec_carry),
      .load         (load_wr),
      .load_val     (ld_mm),
      .count        (minutes_o),
      .carry        (min_carry)
   );

   bcd_mod_counter #(.WRAP_VAL(HR_MAX), .RESTART_VAL(HR_RESTART), .RESET_VAL(HR_RST)) u_hr (
      .clk_100MHz_i (clk_100MHz_i),
      .reset_n_i    (reset_n_i),
      .inc          (min_carry),
      .load         (load_wr),
      .load_val     (ld_hh),
      .count        (hours_o),
      .carry        (hr_carry)
   );

   always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state         <= RUN;
         ld_hh         <= 8'h00;
         ld_mm         <= 8'h00;
         ld_ss         <= 8'h00;
         pm_q          <= 1'b0;
         load_ack_o    <= 1'b0;
         load_err_o    <= 1'b0;
         minute_tick_o <= 1'b0;
         day_wrap_o    <= 1'b0;
      end else begin
         load_ack_o    <= 1'b0;
         load_err_o    <= 1'b0;
         minute_tick_o <= sec_carry;
         // In 12h mode the day ends at 11:59:59 PM, i.e. when pm falls.
         day_wrap_o    <= FORMAT_24H ? hr_carry : (pm_flip && pm_q);
         if (pm_flip) begin
            pm_q <= ~pm_q;
         end
         case (state)
            RUN, PAUSED: begin
               if (load_i) begin
                  ld_hh <= load_hh_i;
                  ld_mm <= load_mm_i;
                  ld_ss <= load_ss_i;
                  state <= LOAD;
               end else begin
                  state <= pause_i ? PAUSED : RUN;
               end
            end
            LOAD: begin
               load_ack_o <= load_ok;
               load_err_o <= !load_ok;
               state      <= pause_i ? PAUSED : RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef ALARM_EN
   bcd2_t      alarm_hh_q, alarm_mm_q;
   logic       alarm_pm_q, alarm_q;
   logic [5:0] alarm_secs;

   // Match is taken from the registered minute tick, so alarm_o rises one cycle after HH:MM:00 shows.
   always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         alarm_hh_q <= HR_RST;
         alarm_mm_q <= 8'h00;
         alarm_pm_q <= 1'b0;
         alarm_q    <= 1'b0;
         alarm_secs <= 6'd0;
      end else if (alarm_set_i) begin
         alarm_hh_q <= alarm_hh_i;
         alarm_mm_q <= alarm_mm_i;
         alarm_pm_q <= FORMAT_24H ? 1'b0 : alarm_pm_i;
         alarm_q    <= 1'b0;
         alarm_secs <= 6'd0;
      end else if (!alarm_q) begin
         if (minute_tick_o && (hours_o == alarm_hh_q) && (minutes_o == alarm_mm_q) &&
             (pm_o == alarm_pm_q)) begin
            alarm_q    <= 1'b1;
            alarm_secs <= 6'd0;
         end
      end else if (advance) begin
         if (alarm_secs == 6'd59) begin
            alarm_q <= 1'b0;
         end else begin
            alarm_secs <= alarm_secs + 6'd1;
         end
      end
   end

   assign alarm_o = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: 24h and 12h instances share stimulus and are checked every cycle
// against a seconds-of-day reference model, plus directed boundary checks.
module tb_bcd_time_counter;

   logic       clk_100MHz_i;
   logic       reset_n_i;
   logic       second_pulse_i, pause_i, load_i;
   logic [7:0] load_hh_i, load_mm_i, load_ss_i;

   logic       ack24, err24, pm24, mt24, dw24;
   logic [7:0] hh24, mm24, ss24;
   logic       ack12, err12, pm12, mt12, dw12;
   logic [7:0] hh12, mm12, ss12;

`ifdef ALARM_EN
   logic       alarm_set_i, alarm_pm_i;
   logic [7:0] alarm_hh_i, alarm_mm_i;
   logic       alarm24, alarm12;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: time as seconds since midnight.
   int         t24, t12;
   bit         pend, paused;
   logic [7:0] cap_hh, cap_mm, cap_ss;
   bit         e_ack24, e_err24, e_mt24, e_dw24;
   bit         e_ack12, e_err12, e_mt12, e_dw12;

   initial clk_100MHz_i = 1'b0;
   always #5 clk_100MHz_i = ~clk_100MHz_i;

   bcd_time_counter #(.FORMAT_24H(1'b1)) dut24 (
      .clk_100MHz_i   (clk_100MHz_i),
      .reset_n_i      (reset_n_i),
      .second_pulse_i (second_pulse_i),
      .pause_i        (pause_i),
      .load_i         (load_i),
      .load_hh_i      (load_hh_i),
      .load_mm_i      (load_mm_i),
      .load_ss_i      (load_ss_i),
`ifdef ALARM_EN
      .alarm_set_i    (alarm_set_i),
      .alarm_hh_i     (alarm_hh_i),
      .alarm_mm_i     (alarm_mm_i),
      .alarm_pm_i     (alarm_pm_i),
      .alarm_o        (alarm24),
`endif
      .load_ack_o     (ack24),
      .load_err_o     (err24),
      .hours_o        (hh24),
      .minutes_o      (mm24),
      .seconds_o      (ss24),
      .pm_o           (pm24),
      .minute_tick_o  (mt24),
      .day_wrap_o     (dw24)
   );

   bcd_time_counter #(.FORMAT_24H(1'b0)) dut12 (
      .clk_100MHz_i   (clk_100MHz_i),
      .reset_n_i      (reset_n_i),
      .second_pulse_i (second_pulse_i),
      .pause_i        (pause_i),
      .load_i         (load_i),
      .load_hh_i      (load_hh_i),
      .load_mm_i      (load_mm_i),
      .load_ss_i      (load_ss_i),
`ifdef ALARM_EN
      .alarm_set_i    (alarm_set_i),
      .alarm_hh_i     (alarm_hh_i),
      .alarm_mm_i     (alarm_mm_i),
      .alarm_pm_i     (alarm_pm_i),
      .alarm_o        (alarm12),
`endif
      .load_ack_o     (ack12),
      .load_err_o     (err12),
      .hours_o        (hh12),
      .minutes_o      (mm12),
      .seconds_o      (ss12),
      .pm_o           (pm12),
      .minute_tick_o  (mt12),
      .day_wrap_o     (dw12)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int bcd_val(input logic [7:0] b);
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] tens, units;
      tens  = 4'(v / 10);
      units = 4'(v % 10);
      return {tens, units};
   endfunction

   // Seconds-of-day for a load request, or -1 if it must be rejected.
   function automatic int load_secs(input logic [7:0] hh, input logic [7:0] mm,
                                    input logic [7:0] ss, input bit is24, input bit pm);
      int h, m, s;
      h = bcd_val(hh);
      m = bcd_val(mm);
      s = bcd_val(ss);
      if (h < 0 || m < 0 || s < 0 || m > 59 || s > 59) return -1;
      if (is24) begin
         if (h > 23) return -1;
         return h * 3600 + m * 60 + s;
      end
      if (h < 1 || h > 12) return -1;
      return ((h % 12) + (pm ? 12 : 0)) * 3600 + m * 60 + s;
   endfunction

   task automatic model_reset();
      t24 = 0; t12 = 0; pend = 0; paused = 0;
      {e_ack24, e_err24, e_mt24, e_dw24} = 4'b0;
      {e_ack12, e_err12, e_mt12, e_dw12} = 4'b0;
   endtask

   task automatic model_edge(input bit tk, input bit pz, input bit ld,
                             input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      int n;
      {e_ack24, e_err24, e_mt24, e_dw24} = 4'b0;
      {e_ack12, e_err12, e_mt12, e_dw12} = 4'b0;
      if (pend) begin
         n = load_secs(cap_hh, cap_mm, cap_ss, 1'b1, 1'b0);
         if (n >= 0) begin t24 = n; e_ack24 = 1; end else e_err24 = 1;
         n = load_secs(cap_hh, cap_mm, cap_ss, 1'b0, t12 >= 43200);
         if (n >= 0) begin t12 = n; e_ack12 = 1; end else e_err12 = 1;
         pend = 0;
      end else if (ld) begin
         cap_hh = hh; cap_mm = mm; cap_ss = ss;
         pend = 1;
      end else if (tk && !paused) begin
         t24 = (t24 + 1) % 86400;
         t12 = (t12 + 1) % 86400;
         e_mt24 = (t24 % 60 == 0); e_dw24 = (t24 == 0);
         e_mt12 = (t12 % 60 == 0); e_dw12 = (t12 == 0);
      end
      paused = pz;
   endtask

   task automatic check_all();
      int h, h12;
      h = t24 / 3600;
      chk("hours24",   hh24, to_bcd(h));
      chk("minutes24", mm24, to_bcd((t24 / 60) % 60));
      chk("seconds24", ss24, to_bcd(t24 % 60));
      chk("pm24",      pm24, 0);
      chk("ack24", ack24, e_ack24);
      chk("err24", err24, e_err24);
      chk("mtick24", mt24, e_mt24);
      chk("dwrap24", dw24, e_dw24);
      h   = t12 / 3600;
      h12 = (h % 12 == 0) ? 12 : h % 12;
      chk("hours12",   hh12, to_bcd(h12));
      chk("minutes12", mm12, to_bcd((t12 / 60) % 60));
      chk("seconds12", ss12, to_bcd(t12 % 60));
      chk("pm12",      pm12, h >= 12);
      chk("ack12", ack12, e_ack12);
      chk("err12", err12, e_err12);
      chk("mtick12", mt12, e_mt12);
      chk("dwrap12", dw12, e_dw12);
   endtask

   // Inputs change at the falling edge; outputs are checked at the next falling edge.
   task automatic step(input bit tk, input bit pz, input bit ld,
                       input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
      second_pulse_i = tk; pause_i = pz; load_i = ld;
      load_hh_i = hh; load_mm_i = mm; load_ss_i = ss;
      @(posedge clk_100MHz_i);
      model_edge(tk, pz, ld, hh, mm, ss);
      @(negedge clk_100MHz_i);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic tick();
      step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   // load_i cycle then LOAD cycle; the ack/err is visible after the second step.
   task automatic do_load(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                          input bit tk);
      step(tk, 1'b0, 1'b1, hh, mm, ss);
      step(tk, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic apply_reset();
      reset_n_i = 1'b0;
      second_pulse_i = 0; pause_i = 0; load_i = 0;
      model_reset();
      #2;
      check_all();
      @(negedge clk_100MHz_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      logic [7:0] hh, mm, ss;
      bit         pz;
      reset_n_i = 1'b0;
      second_pulse_i = 0; pause_i = 0; load_i = 0;
      load_hh_i = 0; load_mm_i = 0; load_ss_i = 0;
`ifdef ALARM_EN
      alarm_set_i = 0; alarm_hh_i = 0; alarm_mm_i = 0; alarm_pm_i = 0;
`endif
      @(negedge clk_100MHz_i);
      apply_reset();
      chk("rst_hours24", hh24, 8'h00);
      chk("rst_hours12", hh12, 8'h12);
      chk("rst_pm12", pm12, 1'b0);

      for (int i = 0; i < 3; i++) begin tick(); idle(1); end
      chk("3tick_ss24", ss24, 8'h03);
      chk("3tick_mm24", mm24, 8'h00);
      chk("3tick_hh24", hh24, 8'h00);
      chk("3tick_ss12", ss12, 8'h03);

`ifdef ALARM_EN
      chk("alarm_rst24", alarm24, 1'b0);
      alarm_hh_i = 8'h07; alarm_mm_i = 8'h30; alarm_pm_i = 1'b0; alarm_set_i = 1'b1;
      idle(1);
      alarm_set_i = 1'b0;
      do_load(8'h07, 8'h29, 8'h59, 1'b0);
      tick();
      idle(1);
      chk("alarm_on24", alarm24, 1'b1);
      chk("alarm_on12", alarm12, 1'b1);
      alarm_set_i = 1'b1;
      idle(1);
      alarm_set_i = 1'b0;
      chk("alarm_clr24", alarm24, 1'b0);
      chk("alarm_clr12", alarm12, 1'b0);
`endif

      do_load(8'h23, 8'h59, 8'h59, 1'b0);
      chk("ld235959_ack24", ack24, 1'b1);
      chk("ld235959_err12", err12, 1'b1);
      tick();
      chk("wrap_hh24", hh24, 8'h00);
      chk("wrap_ss24", ss24, 8'h00);
      chk("wrap_dw24", dw24, 1'b1);
      chk("wrap_mt24", mt24, 1'b1);
      idle(1);
      chk("wrap_dw24_done", dw24, 1'b0);

      do_load(8'h11, 8'h59, 8'h59, 1'b0);
      chk("ld115959_pm12", pm12, 1'b0);
      tick();
      chk("noon_hh12", hh12, 8'h12);
      chk("noon_pm12", pm12, 1'b1);
      do_load(8'h12, 8'h59, 8'h59, 1'b0);
      tick();
      chk("one_hh12", hh12, 8'h01);
      chk("one_mm12", mm12, 8'h00);

      do_load(8'h24, 8'h00, 8'h00, 1'b0);
      chk("bad_hh_err24", err24, 1'b1);
      do_load(8'h10, 8'h00, 8'h5A, 1'b0);
      chk("bad_ss_err24", err24, 1'b1);
      chk("bad_ss_ack24", ack24, 1'b0);
      do_load(8'h10, 8'h20, 8'h30, 1'b1);
      chk("ld102030_ack24", ack24, 1'b1);
      chk("ld102030_ss24", ss24, 8'h30);
      chk("ld102030_ss12", ss12, 8'h30);

      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
         step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      end
      chk("paused_ss24", ss24, 8'h30);
      idle(1);
      tick();
      chk("resume_ss24", ss24, 8'h31);
      chk("resume_mm24", mm24, 8'h20);

      step(1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 8'h05);
      apply_reset();
      idle(2);
      chk("abort_ss24", ss24, 8'h00);

      pz = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(99);
         if ($urandom_range(19) == 0) pz = ~pz;
         hh = ($urandom_range(3) == 0) ? 8'($urandom) : to_bcd($urandom_range(23));
         mm = ($urandom_range(1) == 0) ? 8'h59 : to_bcd($urandom_range(59));
         ss = ($urandom_range(19) == 0) ? 8'($urandom)
            : (($urandom_range(1) == 0) ? 8'h59 : to_bcd($urandom_range(59)));
         step(r < 45, pz, r >= 94, hh, mm, ss);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
